// File: rtl/t07_spi_tft_writer.sv
// MMIO-side TFT writer: decodes a register write and serialises the command/data
// bytes to the panel over SPI mode 0, MSB first, stalling the MMIO via ack_TFT.
module t07_spi_tft_writer #(
   parameter int unsigned CLK_DIV   = 2,
   parameter logic [31:0] BASE_ADDR = 32'd1792
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        wi_in,
   input  logic [31:0] addr_in,
   input  logic [31:0] data_in,
   output logic        ack_TFT,
   output logic        spi_sclk,
   output logic        spi_mosi,
   output logic        spi_cs_n,
   output logic        spi_dc
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned DIV_W  = 8;
   localparam int unsigned CNT_W  = 6;

   typedef enum logic [1:0] {IDLE, SHIFT, HOLD, DONE} state_t;

   state_t              state;
   logic [DATA_W-1:0]   shreg;
   logic [CNT_W-1:0]    bit_cnt;
   logic [CNT_W-1:0]    last_idx;
   logic [DIV_W-1:0]    div;

   logic [DATA_W-1:0]   off_c;
   logic                valid_c;
   logic                dc_c;
   logic [4:0]          len_m1_c;
   logic [DATA_W-1:0]   aligned_c;

   // Register-offset decode: selects frame length and command/data flag
   always_comb begin
      off_c    = addr_in - BASE_ADDR;
      valid_c  = 1'b1;
      dc_c     = 1'b1;
      len_m1_c = 5'd7;
      case (off_c)
         32'd1:   dc_c = 1'b0;
         32'd2:   len_m1_c = 5'd7;
         32'd3:   len_m1_c = 5'd15;
         32'd4:   len_m1_c = 5'd31;
         default: valid_c = 1'b0;
      endcase
      // Left-align the payload so the shift register always emits from bit 31
      aligned_c = data_in << (5'd31 - len_m1_c);
   end

   // Accept-cycle term is combinational so the MMIO stalls in the request cycle
   assign ack_TFT = nrst & ((state == SHIFT) || (state == HOLD) ||
                            ((state == IDLE) && wi_in && valid_c));

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state    <= IDLE;
         shreg    <= '0;
         bit_cnt  <= '0;
         last_idx <= '0;
         div      <= '0;
         spi_sclk <= 1'b0;
         spi_mosi <= 1'b0;
         spi_cs_n <= 1'b1;
         spi_dc   <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (wi_in && valid_c) begin
                  shreg    <= aligned_c;
                  last_idx <= CNT_W'(len_m1_c);
                  bit_cnt  <= '0;
                  div      <= '0;
                  spi_dc   <= dc_c;
                  spi_cs_n <= 1'b0;
                  spi_sclk <= 1'b0;
                  spi_mosi <= aligned_c[DATA_W-1];
                  state    <= SHIFT;
               end
            end
            SHIFT: begin
               if (div == DIV_W'(CLK_DIV - 1)) begin
                  div <= '0;
                  if (!spi_sclk) begin
                     spi_sclk <= 1'b1;
                  end else begin
                     spi_sclk <= 1'b0;
                     // Next bit goes out on the falling edge; last falling edge ends the frame
                     if (bit_cnt == last_idx) begin
                        state <= HOLD;
                     end else begin
                        shreg    <= shreg << 1;
                        spi_mosi <= shreg[DATA_W-2];
                        bit_cnt  <= bit_cnt + CNT_W'(1);
                     end
                  end
               end else begin
                  div <= div + DIV_W'(1);
               end
            end
            HOLD: begin
               if (div == DIV_W'(CLK_DIV - 1)) begin
                  div      <= '0;
                  spi_cs_n <= 1'b1;
                  spi_mosi <= 1'b0;
                  state    <= DONE;
               end else begin
                  div <= div + DIV_W'(1);
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_t07_spi_tft_writer.sv
// Directed bench for t07_spi_tft_writer: frames are decoded from the SPI pins
// and compared with hand-computed bit patterns and cycle counts.
module tb_t07_spi_tft_writer;

   localparam int unsigned CD   = 2;
   localparam int unsigned BASE = 1792;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        wi_in = 1'b0;
   logic [31:0] addr_in = '0;
   logic [31:0] data_in = '0;
   logic        ack_TFT;
   logic        spi_sclk;
   logic        spi_mosi;
   logic        spi_cs_n;
   logic        spi_dc;

   int checks = 0;
   int errors = 0;

   t07_spi_tft_writer #(.CLK_DIV(CD), .BASE_ADDR(32'(BASE))) dut (
      .clk      (clk),
      .nrst     (nrst),
      .wi_in    (wi_in),
      .addr_in  (addr_in),
      .data_in  (data_in),
      .ack_TFT  (ack_TFT),
      .spi_sclk (spi_sclk),
      .spi_mosi (spi_mosi),
      .spi_cs_n (spi_cs_n),
      .spi_dc   (spi_dc)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Called at the negedge of the accept cycle with the write already presented;
   // returns at the negedge of the DONE cycle.
   task automatic run_frame(input string tag, input logic [31:0] exp_bits, input int n,
                            input logic exp_dc, input bit scramble);
      int cyc = 0;
      int first_low = -1;
      int done_cyc = -1;
      int edges = 0;
      int ack_cyc = 0;
      int viol = 0;
      logic [31:0] got = '0;
      logic prev_sclk;
      logic prev_mosi;
      int exp_done;
      exp_done = 1 + 2 * int'(CD) * n + int'(CD);
      #1;
      check({tag, "_ack_accept"}, 32'(ack_TFT), 32'd1);
      if (ack_TFT) ack_cyc++;
      prev_sclk = spi_sclk;
      prev_mosi = spi_mosi;
      while (done_cyc < 0 && cyc < 400) begin
         tick();
         cyc++;
         if (ack_TFT) ack_cyc++;
         if (!spi_cs_n) begin
            if (first_low < 0) first_low = cyc;
            if (spi_dc !== exp_dc) viol++;
         end
         if (spi_sclk && !prev_sclk) begin
            got = {got[30:0], spi_mosi};
            edges++;
         end
         if (spi_sclk && prev_sclk && (spi_mosi !== prev_mosi)) viol++;
         if (spi_sclk && !prev_sclk && (spi_mosi !== prev_mosi)) viol++;
         if (first_low >= 0 && spi_cs_n) done_cyc = cyc;
         prev_sclk = spi_sclk;
         prev_mosi = spi_mosi;
         if (scramble && cyc == 2) begin
            data_in = ~data_in;
            addr_in = 32'(BASE + 1);
         end
      end
      check({tag, "_cs_low_cycle"}, 32'(first_low), 32'd1);
      check({tag, "_done_cycle"},   32'(done_cyc), 32'(exp_done));
      check({tag, "_ack_cycles"},   32'(ack_cyc), 32'(exp_done));
      check({tag, "_ack_done"},     32'(ack_TFT), 32'd0);
      check({tag, "_sclk_done"},    32'(spi_sclk), 32'd0);
      check({tag, "_dc_done"},      32'(spi_dc), 32'(exp_dc));
      check({tag, "_edges"},        32'(edges), 32'(n));
      check({tag, "_bits"},         got, exp_bits);
      check({tag, "_mode0_dc"},     32'(viol), 32'd0);
   endtask

   initial begin
      int gap;
      int rises;
      logic prev_sclk;

      // Reset then idle
      tick();
      check("rst_ack", 32'(ack_TFT), 32'd0);
      tick();
      check("rst_cs", 32'(spi_cs_n), 32'd1);
      nrst = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("idle_cs",   32'(spi_cs_n), 32'd1);
         check("idle_sclk", 32'(spi_sclk), 32'd0);
         check("idle_ack",  32'(ack_TFT),  32'd0);
         check("idle_dc",   32'(spi_dc),   32'd1);
      end

      // Command byte; upper bits of data_in must not be sent
      wi_in = 1'b1; addr_in = 32'(BASE + 1); data_in = 32'hFFFF_FF2A;
      run_frame("cmd", 32'h0000_002A, 8, 1'b0, 1'b0);
      wi_in = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("cmd_no_repeat_cs",  32'(spi_cs_n), 32'd1);
         check("cmd_no_repeat_ack", 32'(ack_TFT),  32'd0);
      end

      // 32-bit data word
      wi_in = 1'b1; addr_in = 32'(BASE + 4); data_in = 32'hDEAD_BEEF;
      run_frame("d32", 32'hDEAD_BEEF, 32, 1'b1, 1'b0);
      wi_in = 1'b0;
      tick();

      // Invalid address is ignored
      wi_in = 1'b1; addr_in = 32'(BASE + 8); data_in = 32'h0000_0033;
      #1;
      check("inv_ack", 32'(ack_TFT), 32'd0);
      for (int i = 0; i < 8; i++) begin
         tick();
         check("inv_cs",  32'(spi_cs_n), 32'd1);
         check("inv_ack_hold", 32'(ack_TFT), 32'd0);
      end

      // Back-to-back 8-bit data writes with wi_in held high
      addr_in = 32'(BASE + 2); data_in = 32'h0000_0011;
      run_frame("b2b_a", 32'h0000_0011, 8, 1'b1, 1'b0);
      gap = spi_cs_n ? 1 : 0;
      data_in = 32'h0000_0022;
      tick();
      if (spi_cs_n) gap++;
      check("b2b_gap", 32'(gap), 32'd2);
      run_frame("b2b_b", 32'h0000_0022, 8, 1'b1, 1'b0);
      wi_in = 1'b0;
      tick();

      // Reset after 5 rising SCLK edges of a 16-bit write
      wi_in = 1'b1; addr_in = 32'(BASE + 3); data_in = 32'h0000_1234;
      rises = 0;
      prev_sclk = spi_sclk;
      for (int i = 0; i < 200 && rises < 5; i++) begin
         tick();
         wi_in = 1'b0;
         if (spi_sclk && !prev_sclk) rises++;
         prev_sclk = spi_sclk;
      end
      check("mid_rises", 32'(rises), 32'd5);
      nrst = 1'b0;
      #1;
      check("mid_ack_in_rst", 32'(ack_TFT), 32'd0);
      tick();
      check("mid_cs",   32'(spi_cs_n), 32'd1);
      check("mid_sclk", 32'(spi_sclk), 32'd0);
      check("mid_ack",  32'(ack_TFT),  32'd0);
      check("mid_dc",   32'(spi_dc),   32'd1);
      nrst = 1'b1;
      tick();
      check("post_rst_cs", 32'(spi_cs_n), 32'd1);
      wi_in = 1'b1; addr_in = 32'(BASE + 2); data_in = 32'h0000_005A;
      run_frame("post_rst", 32'h0000_005A, 8, 1'b1, 1'b0);
      wi_in = 1'b0;
      tick();

      // Inputs changed during SHIFT must not affect the frame
      wi_in = 1'b1; addr_in = 32'(BASE + 2); data_in = 32'h0000_00A5;
      run_frame("hold", 32'h0000_00A5, 8, 1'b1, 1'b1);
      wi_in = 1'b0;
      tick();
      check("hold_idle_cs", 32'(spi_cs_n), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
